// File: rtl/conv_channel_ctrl.sv
// Job sequencer for a 4-channel conv + adder-tree unit: weight load, window admission, result drain.
// Optional DRAIN watchdog with sticky timeout_err is enabled by defining CONV_CTRL_TIMEOUT_EN.
module conv_channel_ctrl #(
  parameter int DataWidth  = 32,
  parameter int InputDim   = 4,
  parameter int KernelSize = 9,
  parameter int CountWidth = 16,
  parameter int WAddrWidth = 8
`ifdef CONV_CTRL_TIMEOUT_EN
  ,parameter int TimeoutCycles = 1024
`endif
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          start,
  input  logic [CountWidth-1:0]         num_windows,
  input  logic [WAddrWidth-1:0]         weight_base,
  output logic                          busy,
  output logic                          done,
  output logic                          wmem_rd_en,
  output logic [WAddrWidth-1:0]         wmem_addr,
  input  logic [InputDim*DataWidth-1:0] wmem_rdata,
  input  logic                          src_valid,
  output logic                          src_ready,
  output logic [InputDim*DataWidth-1:0] conv_weight_in,
  output logic                          conv_weight_valid,
  output logic                          conv_window_valid,
  input  logic                          conv_result_ready,
`ifdef CONV_CTRL_TIMEOUT_EN
  output logic                          timeout_err,
`endif
  output logic [CountWidth-1:0]         result_count
);

  localparam int TapW = $clog2(KernelSize + 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t                state;
  logic [TapW-1:0]       tap;
  logic [CountWidth-1:0] nw_q;
  logic [CountWidth-1:0] issued;
`ifdef CONV_CTRL_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles + 1);
  logic [WdW-1:0] wd;
`endif

  // Memory read data lands the cycle after the strobe, which is when conv_weight_valid is high.
  assign conv_weight_in    = wmem_rdata;
  assign conv_window_valid = src_valid & src_ready;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state             <= IDLE;
      tap               <= '0;
      nw_q              <= '0;
      issued            <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      wmem_rd_en        <= 1'b0;
      wmem_addr         <= '0;
      src_ready         <= 1'b0;
      conv_weight_valid <= 1'b0;
      result_count      <= '0;
`ifdef CONV_CTRL_TIMEOUT_EN
      wd                <= '0;
      timeout_err       <= 1'b0;
`endif
    end else begin
      conv_weight_valid <= wmem_rd_en;
      done              <= 1'b0;
      case (state)
        IDLE: if (start) begin
          nw_q         <= num_windows;
          issued       <= '0;
          result_count <= '0;
          busy         <= 1'b1;
`ifdef CONV_CTRL_TIMEOUT_EN
          timeout_err  <= 1'b0;
`endif
          if (num_windows == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state      <= LOAD;
            wmem_rd_en <= 1'b1;
            wmem_addr  <= weight_base;
            tap        <= '0;
          end
        end
        LOAD: begin
          if (tap == TapW'(KernelSize - 1)) begin
            wmem_rd_en <= 1'b0;
            src_ready  <= 1'b1;
            state      <= RUN;
          end else begin
            tap       <= tap + 1'b1;
            wmem_addr <= wmem_addr + 1'b1;
          end
        end
        RUN: begin
          if (conv_result_ready) result_count <= result_count + 1'b1;
          if (conv_window_valid) begin
            issued <= issued + 1'b1;
            if (issued + 1'b1 == nw_q) begin
              src_ready <= 1'b0;
              state     <= DRAIN;
`ifdef CONV_CTRL_TIMEOUT_EN
              wd        <= '0;
`endif
            end
          end
        end
        DRAIN: begin
          if (conv_result_ready) result_count <= result_count + 1'b1;
          // Leave on the same edge that the final strobe is counted.
          if (result_count == nw_q || (conv_result_ready && result_count + 1'b1 == nw_q)) begin
            state <= DONE;
            done  <= 1'b1;
          end
`ifdef CONV_CTRL_TIMEOUT_EN
          else if (conv_result_ready) wd <= '0;
          else if (wd == WdW'(TimeoutCycles - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else wd <= wd + 1'b1;
`endif
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_channel_ctrl.sv
// Bench for conv_channel_ctrl: directed + randomized jobs against an event-level job model.
module tb_conv_channel_ctrl;
  localparam int DW = 32, ID = 4, KS = 9, CW = 16, AW = 8;

  logic               Clk = 1'b0, Rst = 1'b1, start = 1'b0;
  logic [CW-1:0]      num_windows = '0;
  logic [AW-1:0]      weight_base = '0;
  logic               busy, done, wmem_rd_en, src_ready;
  logic [AW-1:0]      wmem_addr;
  logic [ID*DW-1:0]   wmem_rdata = '0;
  logic               src_valid = 1'b0;
  logic [ID*DW-1:0]   conv_weight_in;
  logic               conv_weight_valid, conv_window_valid;
  logic               conv_result_ready = 1'b0;
  logic [CW-1:0]      result_count;
`ifdef CONV_CTRL_TIMEOUT_EN
  logic               timeout_err;
`endif

  conv_channel_ctrl dut (
    .Clk(Clk), .Rst(Rst), .start(start), .num_windows(num_windows), .weight_base(weight_base),
    .busy(busy), .done(done), .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr),
    .wmem_rdata(wmem_rdata), .src_valid(src_valid), .src_ready(src_ready),
    .conv_weight_in(conv_weight_in), .conv_weight_valid(conv_weight_valid),
    .conv_window_valid(conv_window_valid), .conv_result_ready(conv_result_ready),
`ifdef CONV_CTRL_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .result_count(result_count)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Synchronous weight memory: data valid exactly one cycle after the read strobe.
  logic [ID*DW-1:0] mem [256];
  always @(posedge Clk) wmem_rdata <= wmem_rd_en ? mem[wmem_addr] : '0;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [ID*DW-1:0] obs, input logic [ID*DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Job-level observations, gathered mid-cycle.
  bit               mon_en = 1'b0;
  int               lat = 20, cur_nw = 0;
  int               win_cnt = 0, done_cnt = 0, done_cyc = 0, first_rdy_cyc = -1;
  int               rc_at_done = 0;
  int               res_due[$];
  int               rd_cyc_q[$], wt_cyc_q[$];
  logic [AW-1:0]    rd_addr_q[$];
  logic [ID*DW-1:0] wt_q[$];

  always @(negedge Clk) begin
    // Conv unit: a result strobe exactly lat cycles after each window.
    conv_result_ready = (res_due.size() > 0 && res_due[0] == cyc);
    if (conv_result_ready) void'(res_due.pop_front());
    if (mon_en) begin
      if (wmem_rd_en) begin rd_addr_q.push_back(wmem_addr); rd_cyc_q.push_back(cyc); end
      if (conv_weight_valid) begin wt_q.push_back(conv_weight_in); wt_cyc_q.push_back(cyc); end
      if (src_ready && first_rdy_cyc < 0) first_rdy_cyc = cyc;
      if (win_cnt >= cur_nw) chk("src_ready_after_last", src_ready, 0);
      if (conv_window_valid) begin
        chk("window_needs_src", src_valid, 1);
        win_cnt++;
        res_due.push_back(cyc + lat);
      end
      if (done) begin done_cnt++; done_cyc = cyc; rc_at_done = int'(result_count); end
    end
  end

  task automatic step();
    @(posedge Clk); #1;
  endtask

  function automatic bit pat_valid(input int pat, input int k);
    if (pat == 0) return 1'b1;
    if (pat == 1) return (k % 3) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_job(input int base, input int nw, input int pat, input int l, input bit dup_start);
    int  t0, k;
    bit  dup_done;
    rd_cyc_q.delete(); wt_cyc_q.delete(); rd_addr_q.delete(); wt_q.delete();
    win_cnt = 0; done_cnt = 0; first_rdy_cyc = -1; cur_nw = nw; lat = l;
    dup_done = 1'b0;
    weight_base = AW'(base); num_windows = CW'(nw); start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
      src_valid = pat_valid(pat, k);
      k++;
      if (dup_start && !dup_done && win_cnt == 1) begin
        start = 1'b1; num_windows = CW'(7); dup_done = 1'b1;
      end else start = 1'b0;
      step();
    end
    start = 1'b0; src_valid = 1'b0;
    chk("done_seen", done_cnt > 0, 1);
    repeat (4) step();
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", busy, 0);
    chk("result_count_at_done", rc_at_done, nw);
    chk("result_count_hold", result_count, nw);
    chk("windows_issued", win_cnt, nw);
    chk("read_count", rd_addr_q.size(), nw > 0 ? KS : 0);
    chk("weight_strobes", wt_q.size(), nw > 0 ? KS : 0);
    for (int i = 0; i < rd_addr_q.size() && i < wt_q.size(); i++) begin
      chk("read_addr", rd_addr_q[i], (base + i) % 256);
      chk("weight_data", wt_q[i], mem[(base + i) % 256]);
      chk("weight_lag", wt_cyc_q[i], rd_cyc_q[i] + 1);
      chk("weight_contig", wt_cyc_q[i], wt_cyc_q[0] + i);
    end
    if (nw > 0 && wt_cyc_q.size() == KS) chk("last_weight_first_run", wt_cyc_q[KS-1], first_rdy_cyc);
    if (nw == 0) chk("zero_done_latency", (done_cyc - t0) <= 2, 1);
  endtask

  initial begin
    int rbase;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};

    // Reset state
    Rst = 1'b1;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", wmem_rd_en, 0);
    chk("rst_addr", wmem_addr, 0);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_wvalid", conv_weight_valid, 0);
    chk("rst_result_count", result_count, 0);
    Rst = 1'b0;
    mon_en = 1'b1;
    step();

    run_job(8'h10, 4, 0, 20, 1'b0);                                 // basic
    run_job($urandom_range(0, 255), 6, 1, $urandom_range(3, 15), 1'b0); // backpressure
    run_job($urandom_range(0, 255), 0, 0, 5, 1'b0);                 // zero-length
    run_job($urandom_range(0, 255), 3, 0, 10, 1'b1);                // start during RUN ignored
    run_job(8'hFC, 5, 2, 7, 1'b0);                                  // address wrap

    // Reset in the middle of RUN, with two results still in flight.
    rd_cyc_q.delete(); wt_cyc_q.delete(); rd_addr_q.delete(); wt_q.delete();
    win_cnt = 0; done_cnt = 0; first_rdy_cyc = -1; cur_nw = 5; lat = 20;
    rbase = $urandom_range(0, 255);
    weight_base = AW'(rbase); num_windows = CW'(5); start = 1'b1;
    step();
    start = 1'b0; src_valid = 1'b1;
    for (int i = 0; i < 200 && win_cnt < 2; i++) step();
    chk("two_windows_before_reset", win_cnt, 2);
    src_valid = 1'b0; Rst = 1'b1;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_rd_en", wmem_rd_en, 0);
    chk("midrst_src_ready", src_ready, 0);
    chk("midrst_window_valid", conv_window_valid, 0);
    chk("midrst_wvalid", conv_weight_valid, 0);
    chk("midrst_weight_in", conv_weight_in, 0);
    chk("midrst_result_count", result_count, 0);
    Rst = 1'b0;
    repeat (30) step();
    chk("late_results_ignored", result_count, 0);
    chk("no_done_after_reset", done_cnt, 0);
    chk("late_results_drained", res_due.size(), 0);
    run_job($urandom_range(0, 255), 5, 0, 12, 1'b0);

    // Randomized jobs
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(0, 255), $urandom_range(1, 8), $urandom_range(0, 2),
              $urandom_range(1, 25), 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
